data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/dmem_array.sv | 29 ++
 rtl/data_mem_responder.sv | 103 ++++++++++
 tb/tb_data_mem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the data-memory path.
//   state_t     : responder FSM state encoding
//   mem_req_t   : request fields captured at acceptance
//   OP_LW/OP_SW : MIPS load/store word opcodes
//   DEFAULT_DEPTH : default data-memory size in 32-bit words
package cpu_pkg;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam int DEFAULT_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic        err;
    logic [31:0] wdata;
  } mem_req_t;

  // True when the opcode is one the data-memory path services.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Misaligned byte address, or a word index past the end of the array.
  function automatic logic addr_err(input logic [31:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Data memory storage: DEPTH x 32 bits, synchronous write, combinational read.
// Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   idx   : word index (shared by read and write)
//   wdata : write data
//   rdata : read data at idx
module dmem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one lw/sw at a time, inserts WAIT_CYCLES
// wait states, then holds a response until the CPU takes it.
//   clk, reset             : clock, async active-high reset
//   req_valid/req_ready    : request handshake (ready only in IDLE)
//   req_write              : 1 = store, 0 = load
//   req_addr, req_wdata    : byte address, store data
//   resp_valid/resp_ready  : response handshake
//   resp_rdata, resp_err   : load data (0 for stores/errors), error flag
module data_mem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t        state;
  logic [3:0]    cnt;
  mem_req_t      lat, cur;
  logic [AW-1:0] lat_idx, cur_idx;
  logic          accept, enter_resp, mem_we;
  logic [31:0]   mem_rdata;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // With zero wait states the commit happens on the accepting edge, so the
  // live inputs are used in IDLE; afterwards only the latched copy matters.
  always_comb begin
    cur     = lat;
    cur_idx = lat_idx;
    if (state == IDLE) begin
      cur.write = req_write;
      cur.err   = addr_err(req_addr, DEPTH);
      cur.wdata = req_wdata;
      cur_idx   = req_addr[AW+1:2];
    end
  end

  assign enter_resp = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == LAST_CNT));
  assign mem_we     = enter_resp & cur.write & ~cur.err;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (cur_idx),
    .wdata (cur.wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat        <= '0;
      lat_idx    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          lat     <= cur;
          lat_idx <= cur_idx;
          cnt     <= 4'd0;
          state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) state <= RESP;
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Response fields are loaded once on RESP entry and otherwise held.
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= cur.err;
        resp_rdata <= (cur.write || cur.err) ? 32'd0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  // second instance with zero wait states
  logic        z_req_valid, z_req_write, z_resp_ready;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_req_ready, z_resp_valid, z_resp_err;
  logic [31:0] z_resp_rdata;

  int          errs = 0;
  int          checks = 0;
  int          lat;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request for one edge; returns #1 after the accepting edge.
  task automatic accept(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Count edges (accepting edge = 1) until resp_valid, then take the response.
  task automatic finish(input string tag, input int exp_lat,
                        output logic [31:0] rdata, output logic err);
    int n = 1;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, ".lat"}, n, exp_lat);
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ".vdrop"}, resp_valid, 1'b0);
    chk({tag, ".idle"}, req_ready, 1'b1);
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] r;
    logic        e;
    accept(wr, addr, wdata);
    finish(tag, 3, r, e);
    chk({tag, ".rdata"}, r, exp_rd);
    chk({tag, ".err"}, e, exp_err);
  endtask

  task automatic z_req(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd);
    z_req_valid = 1'b1; z_req_write = wr; z_req_addr = addr; z_req_wdata = wdata;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    chk({tag, ".valid1"}, z_resp_valid, 1'b1);
    chk({tag, ".rdata"}, z_resp_rdata, exp_rd);
    chk({tag, ".err"}, z_resp_err, 1'b0);
    z_resp_ready = 1'b1;
    @(posedge clk); #1;
    z_resp_ready = 1'b0;
    chk({tag, ".vdrop"}, z_resp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_resp_ready = 0;
    #1;
    chk("rst.ready", req_ready, 1'b1);
    chk("rst.valid", resp_valid, 1'b0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.err", resp_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // store then load back, 3-edge latency
    do_req("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    do_req("lw10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // error cases, and index 0 must survive an out-of-range store
    do_req("sw00", 1'b1, 32'h0, 32'hA5A5A5A5, 32'd0, 1'b0);
    do_req("lw13", 1'b0, 32'h13, 32'h0, 32'd0, 1'b1);
    do_req("sw1000", 1'b1, 32'h1000, 32'hFFFFFFFF, 32'd0, 1'b1);
    chk("err.sticky", resp_err, 1'b1);
    do_req("lw00", 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
    chk("err.cleared", resp_err, 1'b0);

    // hold response with resp_ready=0 while a new request is presented
    accept(1'b0, 32'h10, 32'h0);
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("hold.lat", lat, 3);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold.valid", resp_valid, 1'b1);
      chk("hold.rdata", resp_rdata, 32'hDEADBEEF);
      chk("hold.ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    chk("hold.nobypass", req_ready, 1'b1);
    chk("hold.vdrop", resp_valid, 1'b0);
    do_req("hold.reload", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // inputs changed during WAIT must not matter
    do_req("sw28", 1'b1, 32'h28, 32'h28282828, 32'd0, 1'b0);
    accept(1'b1, 32'h24, 32'h0BADF00D);
    req_write = 1'b0; req_addr = 32'h28; req_wdata = 32'hFFFF0000;
    finish("latch", 3, rd, er);
    chk("latch.rdata", rd, 32'd0);
    chk("latch.err", er, 1'b0);
    do_req("latch.lw24", 1'b0, 32'h24, 32'h0, 32'h0BADF00D, 1'b0);
    do_req("latch.lw28", 1'b0, 32'h28, 32'h0, 32'h28282828, 1'b0);

    // reset during WAIT of a store drops it
    do_req("sw20", 1'b1, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
    accept(1'b1, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    chk("wrst.inwait", req_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("wrst.ready", req_ready, 1'b1);
    chk("wrst.valid", resp_valid, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("wrst.stillidle", resp_valid, 1'b0);
    do_req("wrst.lw20", 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // zero wait states: response one edge after acceptance
    z_req("z.sw04", 1'b1, 32'h4, 32'h44444444, 32'd0);
    z_req("z.lw04", 1'b0, 32'h4, 32'h0, 32'h44444444);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
